// File: rtl/heap_pq.sv
// rtl/heap_pq.sv - binary-heap priority queue of key/payload pairs, min- or max-ordered
// One slot array access per cycle; PUSH sifts up, POP/REPLACE sift down.
module heap_pq #(
    parameter int KEY_BITS  = 4,
    parameter int DATA_BITS = 8,
    parameter int DEPTH_LOG = 3,
    parameter int MAX_HEAP  = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           cmd,
    input  logic [KEY_BITS-1:0]  din_key,
    input  logic [DATA_BITS-1:0] din_data,
    output logic [KEY_BITS-1:0]  dout_key,
    output logic [DATA_BITS-1:0] dout_data,
    output logic                 ready,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_LOG:0]   count,
    output logic                 error
);
    localparam int WORDS = 2 ** DEPTH_LOG;
    localparam int CW    = DEPTH_LOG + 1;
    localparam int IW    = DEPTH_LOG + 2;
    localparam logic [CW-1:0] FULL_CNT = CW'(WORDS);

    localparam logic [1:0] CMD_PUSH    = 2'd1;
    localparam logic [1:0] CMD_POP     = 2'd2;
    localparam logic [1:0] CMD_REPLACE = 2'd3;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PUSH_RD  = 3'd1;
    localparam logic [2:0] S_PUSH_CMP = 3'd2;
    localparam logic [2:0] S_DN_RDL   = 3'd3;
    localparam logic [2:0] S_DN_RDR   = 3'd4;
    localparam logic [2:0] S_DN_CMP   = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        posn_q, posn_d;
    logic [KEY_BITS-1:0]  hold_key_q, hold_key_d, tmp1_key_q, tmp1_key_d, tmp2_key_q, tmp2_key_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d, tmp1_data_q, tmp1_data_d, tmp2_data_q, tmp2_data_d;
    logic                 error_q, error_d;
    logic [KEY_BITS-1:0]  slot_key_q  [WORDS];
    logic [DATA_BITS-1:0] slot_data_q [WORDS];

    logic                 wr_en;
    logic [DEPTH_LOG-1:0] wr_idx, rd_idx;
    logic [KEY_BITS-1:0]  wr_key, rd_key;
    logic [DATA_BITS-1:0] wr_data, rd_data;

    logic [CW-1:0] cnt_m1, parent;
    logic [IW-1:0] posn_x, count_x, left_x, right_x;
    logic          l_in, r_in, l_ok, r_ok;

    function automatic logic better(input logic [KEY_BITS-1:0] a, input logic [KEY_BITS-1:0] b);
        return (MAX_HEAP != 0) ? (a > b) : (a < b);
    endfunction

    // Child indices carry one bit more than count so right(WORDS-1) cannot wrap onto slot 0.
    assign cnt_m1  = count_q - 1'b1;
    assign parent  = (posn_q - 1'b1) >> 1;
    assign posn_x  = {1'b0, posn_q};
    assign count_x = {1'b0, count_q};
    assign left_x  = (posn_x << 1) + IW'(1);
    assign right_x = (posn_x << 1) + IW'(2);
    assign l_in    = left_x < count_x;
    assign r_in    = right_x < count_x;
    assign l_ok    = l_in && better(tmp1_key_q, hold_key_q) && (!r_in || !better(tmp2_key_q, tmp1_key_q));
    assign r_ok    = r_in && better(tmp2_key_q, hold_key_q);

    always_comb begin
        rd_idx = '0;
        case (state_q)
            S_IDLE:    rd_idx = cnt_m1[DEPTH_LOG-1:0];
            S_PUSH_RD: rd_idx = parent[DEPTH_LOG-1:0];
            S_DN_RDL:  rd_idx = left_x[DEPTH_LOG-1:0];
            S_DN_RDR:  rd_idx = right_x[DEPTH_LOG-1:0];
            default:   rd_idx = '0;
        endcase
    end

    assign rd_key  = slot_key_q[rd_idx];
    assign rd_data = slot_data_q[rd_idx];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        posn_d      = posn_q;
        hold_key_d  = hold_key_q;
        hold_data_d = hold_data_q;
        tmp1_key_d  = tmp1_key_q;
        tmp1_data_d = tmp1_data_q;
        tmp2_key_d  = tmp2_key_q;
        tmp2_data_d = tmp2_data_q;
        error_d     = error_q;
        wr_en       = 1'b0;
        wr_idx      = posn_q[DEPTH_LOG-1:0];
        wr_key      = hold_key_q;
        wr_data     = hold_data_q;
        case (state_q)
            S_IDLE: begin
                if (cmd == CMD_PUSH || (cmd == CMD_REPLACE && empty)) begin
                    if (full) begin
                        error_d = 1'b1;
                    end else begin
                        posn_d      = count_q;
                        hold_key_d  = din_key;
                        hold_data_d = din_data;
                        count_d     = count_q + 1'b1;
                        state_d     = S_PUSH_RD;
                    end
                end else if (cmd == CMD_POP) begin
                    if (empty) begin
                        error_d = 1'b1;
                    end else begin
                        count_d     = cnt_m1;
                        hold_key_d  = rd_key;
                        hold_data_d = rd_data;
                        wr_en       = 1'b1;
                        wr_idx      = '0;
                        wr_key      = rd_key;
                        wr_data     = rd_data;
                        posn_d      = '0;
                        state_d     = S_DN_RDL;
                    end
                end else if (cmd == CMD_REPLACE) begin
                    hold_key_d  = din_key;
                    hold_data_d = din_data;
                    wr_en       = 1'b1;
                    wr_idx      = '0;
                    wr_key      = din_key;
                    wr_data     = din_data;
                    posn_d      = '0;
                    state_d     = S_DN_RDL;
                end
            end
            S_PUSH_RD: begin
                tmp1_key_d  = rd_key;
                tmp1_data_d = rd_data;
                state_d     = S_PUSH_CMP;
            end
            S_PUSH_CMP: begin
                wr_en = 1'b1;
                if (posn_q == '0 || !better(hold_key_q, tmp1_key_q)) begin
                    state_d = S_IDLE;
                end else begin
                    wr_key  = tmp1_key_q;
                    wr_data = tmp1_data_q;
                    posn_d  = parent;
                    state_d = S_PUSH_RD;
                end
            end
            S_DN_RDL: begin
                tmp1_key_d  = rd_key;
                tmp1_data_d = rd_data;
                state_d     = S_DN_RDR;
            end
            S_DN_RDR: begin
                tmp2_key_d  = rd_key;
                tmp2_data_d = rd_data;
                state_d     = S_DN_CMP;
            end
            S_DN_CMP: begin
                wr_en = 1'b1;
                if (l_ok) begin
                    wr_key  = tmp1_key_q;
                    wr_data = tmp1_data_q;
                    posn_d  = left_x[CW-1:0];
                    state_d = S_DN_RDL;
                end else if (r_ok) begin
                    wr_key  = tmp2_key_q;
                    wr_data = tmp2_data_q;
                    posn_d  = right_x[CW-1:0];
                    state_d = S_DN_RDL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            posn_q      <= '0;
            hold_key_q  <= '0;
            hold_data_q <= '0;
            tmp1_key_q  <= '0;
            tmp1_data_q <= '0;
            tmp2_key_q  <= '0;
            tmp2_data_q <= '0;
            error_q     <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                slot_key_q[i]  <= '0;
                slot_data_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            posn_q      <= posn_d;
            hold_key_q  <= hold_key_d;
            hold_data_q <= hold_data_d;
            tmp1_key_q  <= tmp1_key_d;
            tmp1_data_q <= tmp1_data_d;
            tmp2_key_q  <= tmp2_key_d;
            tmp2_data_q <= tmp2_data_d;
            error_q     <= error_d;
            if (wr_en) begin
                slot_key_q[wr_idx]  <= wr_key;
                slot_data_q[wr_idx] <= wr_data;
            end
        end
    end

    assign dout_key  = slot_key_q[0];
    assign dout_data = slot_data_q[0];
    assign ready     = (state_q == S_IDLE);
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign error     = error_q;
endmodule

// File: tb/tb_heap_pq.sv
// tb/tb_heap_pq.sv - directed-vector bench for heap_pq, one min-heap and one max-heap instance
module tb_heap_pq;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] cmd = 2'd0;
    logic [3:0] din_key = '0;
    logic [7:0] din_data = '0;

    logic [3:0] dk_a, dk_b;
    logic [7:0] dd_a, dd_b;
    logic       rdy_a, rdy_b, full_a, full_b, empty_a, empty_b, err_a, err_b;
    logic [3:0] cnt_a, cnt_b;

    int n_chk = 0;
    int n_pass = 0;
    int lat_a, lat_b;

    localparam logic [1:0] NOOP = 2'd0, PUSH = 2'd1, POP = 2'd2, REPL = 2'd3;

    heap_pq #(.KEY_BITS(4), .DATA_BITS(8), .DEPTH_LOG(3), .MAX_HEAP(0)) dut_a (
        .clock(clock), .reset(reset), .cmd(cmd), .din_key(din_key), .din_data(din_data),
        .dout_key(dk_a), .dout_data(dd_a), .ready(rdy_a), .full(full_a), .empty(empty_a),
        .count(cnt_a), .error(err_a)
    );

    heap_pq #(.KEY_BITS(4), .DATA_BITS(8), .DEPTH_LOG(3), .MAX_HEAP(1)) dut_b (
        .clock(clock), .reset(reset), .cmd(cmd), .din_key(din_key), .din_data(din_data),
        .dout_key(dk_b), .dout_data(dd_b), .ready(rdy_b), .full(full_b), .empty(empty_b),
        .count(cnt_b), .error(err_b)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Issue one command, then wait (bounded) until both instances are ready again.
    task automatic op(input logic [1:0] c, input logic [3:0] k, input logic [7:0] d);
        int n;
        @(negedge clock);
        cmd = c; din_key = k; din_data = d;
        @(posedge clock);
        @(negedge clock);
        cmd = NOOP;
        lat_a = 0; lat_b = 0; n = 0;
        while (!(rdy_a && rdy_b)) begin
            if (!rdy_a) lat_a++;
            if (!rdy_b) lat_b++;
            n++;
            if (n > 60) begin
                chk("ready_timeout", 0, 1);
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [3:0] pk [4] = '{4'd5, 4'd3, 4'd7, 4'd1};
    logic [7:0] pd [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [3:0] ptop [4] = '{4'd5, 4'd3, 4'd3, 4'd1};
    logic [3:0] pop_k [3] = '{4'd3, 4'd5, 4'd7};
    logic [7:0] pop_d [3] = '{8'hA1, 8'hA0, 8'hA2};
    logic [3:0] mk [4] = '{4'd2, 4'd9, 4'd4, 4'd9};
    logic [3:0] morder [4] = '{4'd9, 4'd9, 4'd4, 4'd2};
    logic [3:0] rk [4] = '{4'd1, 4'd4, 4'd2, 4'd6};
    logic [3:0] rdrain [4] = '{4'd2, 4'd4, 4'd5, 4'd6};

    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", rdy_a, 1);
        chk("rst_empty", empty_a, 1);
        chk("rst_full", full_a, 0);
        chk("rst_count", cnt_a, 0);
        chk("rst_dkey", dk_a, 0);
        chk("rst_ddata", dd_a, 0);
        chk("rst_error", err_a, 0);

        for (int i = 0; i < 4; i++) begin
            op(PUSH, pk[i], pd[i]);
            chk($sformatf("push%0d_top", i), dk_a, ptop[i]);
        end
        chk("push_lat_m2", lat_a, 6);
        chk("push_data", dd_a, 8'hA3);
        chk("push_count", cnt_a, 4);

        for (int i = 0; i < 3; i++) begin
            op(POP, 4'd0, 8'd0);
            chk($sformatf("pop%0d_key", i), dk_a, pop_k[i]);
            chk($sformatf("pop%0d_data", i), dd_a, pop_d[i]);
            chk($sformatf("pop%0d_count", i), cnt_a, 3 - i);
        end
        op(POP, 4'd0, 8'd0);
        chk("pop_last_empty", empty_a, 1);
        chk("pop_last_count", cnt_a, 0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            op(PUSH, mk[i], 8'hB0 + 8'(i));
            if (i == 0) chk("max_first_lat", lat_b, 2);
        end
        chk("max_eq_lat", lat_b, 4);
        chk("max_top_data", dd_b, 8'hB1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("max_pop%0d", i), dk_b, morder[i]);
            op(POP, 4'd0, 8'd0);
        end
        chk("max_drained", empty_b, 1);

        do_reset();
        for (int i = 0; i < 8; i++) op(PUSH, 4'(i), 8'(i));
        chk("fill_full", full_a, 1);
        chk("fill_err0", err_a, 0);
        op(PUSH, 4'd9, 8'd9);
        chk("ovf_lat", lat_a, 0);
        chk("ovf_count", cnt_a, 8);
        chk("ovf_error", err_a, 1);

        do_reset();
        chk("rst_err_clear", err_a, 0);
        op(POP, 4'd0, 8'd0);
        chk("unf_lat", lat_a, 0);
        chk("unf_error", err_a, 1);
        chk("unf_count", cnt_a, 0);

        do_reset();
        for (int i = 0; i < 4; i++) op(PUSH, rk[i], 8'(i));
        op(REPL, 4'd5, 8'h55);
        chk("repl_count", cnt_a, 4);
        chk("repl_lat", lat_a, 6);
        chk("repl_top", dk_a, 2);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("repl_drain%0d", i), dk_a, rdrain[i]);
            op(POP, 4'd0, 8'd0);
        end
        chk("repl_empty", empty_a, 1);

        op(POP, 4'd0, 8'd0);
        chk("mid_err_set", err_a, 1);
        op(PUSH, 4'd6, 8'd1);
        op(PUSH, 4'd2, 8'd2);
        op(PUSH, 4'd8, 8'd3);
        @(negedge clock);
        cmd = POP;
        @(posedge clock);
        @(negedge clock);
        cmd = NOOP;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("mid_busy", rdy_a, 0);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        @(negedge clock);
        chk("mid_ready", rdy_a, 1);
        chk("mid_count", cnt_a, 0);
        chk("mid_error", err_a, 0);
        op(PUSH, 4'd3, 8'h33);
        chk("mid_push_top", dk_a, 3);
        chk("mid_push_data", dd_a, 8'h33);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
